otter_pc_fetch: RTL and testbench

- Program-counter and instruction-fetch stage of the OTTER core, directly downstream of the branch address generator.
- Consumes the JAL, JALR and BRANCH targets, plus the trap vectors MTVEC and MEPC.
- Selects the next PC, checks alignment, holds the PC register, and runs a request/grant/response handshake with instruction memory.
- Presents one fetched instruction at a time to decode.

---
 rtl/otter_pkg.sv | 22 ++
 rtl/otter_pc_next_mux.sv | 69 ++++++
 rtl/otter_pc_fetch.sv | 118 +++++++++++
 tb/tb_otter_pc_fetch.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// Shared types and constants for the OTTER PC/fetch stage.
package otter_pkg;

  typedef enum logic [2:0] {
    PC_PLUS4  = 3'd0,
    PC_JALR   = 3'd1,
    PC_BRANCH = 3'd2,
    PC_JAL    = 3'd3,
    PC_MTVEC  = 3'd4,
    PC_MEPC   = 3'd5
  } pc_sel_t;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } fetch_state_t;

  // Decode substitutes this when INSTR_VALID is low.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/otter_pc_next_mux.sv
// Next-PC selection: target mux, JALR bit-0 masking, alignment check and
// redirect to the trap vector on a misaligned jump or branch.
module otter_pc_next_mux
  import otter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      pc_sel,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] jal,
  input  logic [XLEN-1:0] jalr,
  input  logic [XLEN-1:0] branch,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] next_pc,
  output logic            misalign,
  output logic [XLEN-1:0] bad_addr
);

  logic [XLEN-1:0] mtvec_aligned;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] raw_target;
  logic            checked;

  assign pc_plus4      = pc + XLEN'(4);
  assign mtvec_aligned = mtvec & ~XLEN'(3);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves a value unassigned (which would infer a latch).
  always_comb begin
    target     = pc_plus4;
    raw_target = pc_plus4;
    checked    = 1'b0;
    case (pc_sel)
      PC_JALR: begin
        raw_target = jalr;
        target     = jalr & ~XLEN'(1);
        checked    = 1'b1;
      end
      PC_BRANCH: begin
        raw_target = branch;
        target     = branch;
        checked    = 1'b1;
      end
      PC_JAL: begin
        raw_target = jal;
        target     = jal;
        checked    = 1'b1;
      end
      PC_MTVEC: begin
        raw_target = mtvec;
        target     = mtvec_aligned;
      end
      PC_MEPC: begin
        raw_target = mepc;
        target     = mepc & ~XLEN'(3);
      end
      default: ;
    endcase
  end

  // Trap vectors are pre-aligned and PC+4 of an aligned PC is aligned,
  // so only the three control-transfer targets are checked.
  assign misalign = checked && (target[1:0] != 2'b00);
  assign next_pc  = misalign ? mtvec_aligned : target;
  assign bad_addr = raw_target;

endmodule

// File: rtl/otter_pc_fetch.sv
// OTTER program counter and instruction-fetch stage: holds the PC and runs
// a request/grant/response handshake, presenting one instruction to decode.
module otter_pc_fetch
  import otter_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [2:0]      PC_SEL,
  input  logic            PC_WE,
  input  logic [XLEN-1:0] JAL,
  input  logic [XLEN-1:0] JALR,
  input  logic [XLEN-1:0] BRANCH,
  input  logic [XLEN-1:0] MTVEC,
  input  logic [XLEN-1:0] MEPC,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_GNT,
  input  logic            IMEM_RVALID,
  input  logic [XLEN-1:0] IMEM_RDATA,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_PLUS4,
  output logic [XLEN-1:0] INSTR,
  output logic            INSTR_VALID,
  output logic            TRAP_MISALIGN,
  output logic [XLEN-1:0] BAD_ADDR
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            instr_valid_q, instr_valid_d;
  logic            trap_q, trap_d;
  logic [XLEN-1:0] bad_addr_q, bad_addr_d;

  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] mux_bad_addr;
  logic            misalign;

  otter_pc_next_mux #(
    .XLEN(XLEN)
  ) u_next_mux (
    .pc_sel   (PC_SEL),
    .pc       (pc_q),
    .jal      (JAL),
    .jalr     (JALR),
    .branch   (BRANCH),
    .mtvec    (MTVEC),
    .mepc     (MEPC),
    .pc_plus4 (PC_PLUS4),
    .next_pc  (next_pc),
    .misalign (misalign),
    .bad_addr (mux_bad_addr)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    trap_d        = 1'b0;
    bad_addr_d    = bad_addr_q;
    case (state_q)
      // A response seen here is stale (issued before a reset) and is dropped.
      S_REQ: begin
        if (IMEM_GNT) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (IMEM_RVALID) begin
          instr_d       = IMEM_RDATA;
          instr_valid_d = 1'b1;
          state_d       = S_VALID;
        end
      end
      S_VALID: begin
        if (PC_WE) begin
          pc_d          = next_pc;
          instr_valid_d = 1'b0;
          trap_d        = misalign;
          state_d       = S_REQ;
          if (misalign) bad_addr_d = mux_bad_addr;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_VEC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      trap_q        <= 1'b0;
      bad_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      trap_q        <= trap_d;
      bad_addr_q    <= bad_addr_d;
    end
  end

  assign IMEM_REQ      = (state_q == S_REQ);
  assign IMEM_ADDR     = pc_q;
  assign PC            = pc_q;
  assign INSTR         = instr_q;
  assign INSTR_VALID   = instr_valid_q;
  assign TRAP_MISALIGN = trap_q;
  assign BAD_ADDR      = bad_addr_q;

endmodule

// File: tb/tb_otter_pc_fetch.sv
// Self-checking bench for otter_pc_fetch: directed scenarios followed by
// randomized jumps and memory stalls against a behavioural PC model.
module tb_otter_pc_fetch;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [2:0]  PC_SEL;
  logic        PC_WE;
  logic [31:0] JAL, JALR, BRANCH, MTVEC, MEPC;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT, IMEM_RVALID;
  logic [31:0] IMEM_RDATA;
  logic [31:0] PC, PC_PLUS4, INSTR, BAD_ADDR;
  logic        INSTR_VALID, TRAP_MISALIGN;

  otter_pc_fetch #(.XLEN(32), .RESET_VEC(32'h0000_0000)) dut (
    .CLK(CLK), .RST_N(RST_N), .PC_SEL(PC_SEL), .PC_WE(PC_WE),
    .JAL(JAL), .JALR(JALR), .BRANCH(BRANCH), .MTVEC(MTVEC), .MEPC(MEPC),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_GNT(IMEM_GNT),
    .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
    .PC(PC), .PC_PLUS4(PC_PLUS4), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
    .TRAP_MISALIGN(TRAP_MISALIGN), .BAD_ADDR(BAD_ADDR)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] model_pc;
  logic        trap_pending;
  logic [31:0] bad_exp;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation timed out");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  // Instruction memory contents are a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Reference next-PC rule, stated as plain address arithmetic.
  function automatic void ref_next(input logic [2:0] sel, input logic [31:0] cur,
                                   input logic [31:0] jal_v, input logic [31:0] jalr_v,
                                   input logic [31:0] br_v, input logic [31:0] mtvec_v,
                                   input logic [31:0] mepc_v, output logic [31:0] npc,
                                   output logic trap, output logic [31:0] bad);
    logic [31:0] tgt;
    logic [31:0] raw;
    bit          jump;
    jump = 1'b1;
    case (sel)
      3'd1:    begin raw = jalr_v; tgt = jalr_v - (jalr_v % 2); end
      3'd2:    begin raw = br_v;   tgt = br_v; end
      3'd3:    begin raw = jal_v;  tgt = jal_v; end
      3'd4:    begin raw = mtvec_v; tgt = mtvec_v - (mtvec_v % 4); jump = 1'b0; end
      3'd5:    begin raw = mepc_v;  tgt = mepc_v - (mepc_v % 4);   jump = 1'b0; end
      default: begin raw = cur + 4; tgt = cur + 4; jump = 1'b0; end
    endcase
    trap = jump && (tgt % 4 != 0);
    bad  = raw;
    npc  = trap ? mtvec_v - (mtvec_v % 4) : tgt;
  endfunction

  // Starts in S_REQ at a negedge; ends in S_VALID at a negedge.
  task automatic fetch(input int gnt_dly, input int rv_dly, input bit stray_we);
    logic [31:0] w;
    w = mem_word(model_pc);
    for (int i = 0; i <= gnt_dly; i++) begin
      check("req_high", {31'd0, IMEM_REQ}, 32'd1);
      check("req_addr", IMEM_ADDR, model_pc);
      check("ivalid_req", {31'd0, INSTR_VALID}, 32'd0);
      check("trap_req", {31'd0, TRAP_MISALIGN}, {31'd0, trap_pending});
      if (trap_pending) check("bad_addr", BAD_ADDR, bad_exp);
      trap_pending = 1'b0;
      IMEM_GNT    = (i == gnt_dly);
      IMEM_RVALID = ($urandom_range(0, 1) == 1);
      IMEM_RDATA  = $urandom;
      PC_WE       = stray_we;
      PC_SEL      = 3'($urandom_range(0, 7));
      JAL         = $urandom;
      step();
    end
    IMEM_GNT = 1'b0;
    for (int i = 0; i <= rv_dly; i++) begin
      check("req_low_wait", {31'd0, IMEM_REQ}, 32'd0);
      check("pc_hold_wait", PC, model_pc);
      check("ivalid_wait", {31'd0, INSTR_VALID}, 32'd0);
      check("trap_wait", {31'd0, TRAP_MISALIGN}, 32'd0);
      IMEM_RVALID = (i == rv_dly);
      IMEM_RDATA  = (i == rv_dly) ? w : $urandom;
      PC_WE       = stray_we;
      step();
    end
    IMEM_RVALID = 1'b0;
    PC_WE       = 1'b0;
    check("ivalid_set", {31'd0, INSTR_VALID}, 32'd1);
    check("instr", INSTR, w);
    check("pc_valid", PC, model_pc);
    check("req_low_valid", {31'd0, IMEM_REQ}, 32'd0);
  endtask

  // Issues PC_WE from S_VALID and updates the model.
  task automatic advance(input logic [2:0] sel, input logic [31:0] jal_v,
                         input logic [31:0] jalr_v, input logic [31:0] br_v,
                         input logic [31:0] mtvec_v, input logic [31:0] mepc_v);
    logic [31:0] npc, bad;
    logic        trap;
    check("pc_plus4", PC_PLUS4, model_pc + 32'd4);
    ref_next(sel, model_pc, jal_v, jalr_v, br_v, mtvec_v, mepc_v, npc, trap, bad);
    PC_SEL = sel; JAL = jal_v; JALR = jalr_v; BRANCH = br_v; MTVEC = mtvec_v; MEPC = mepc_v;
    PC_WE  = 1'b1;
    step();
    PC_WE        = 1'b0;
    model_pc     = npc;
    trap_pending = trap;
    bad_exp      = bad;
    check("pc_after_we", PC, model_pc);
  endtask

  function automatic logic [31:0] rand_tgt(input bit is_jalr);
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 3) != 0) v[1:0] = 2'b00;
    if (is_jalr && v[1]) v[0] = 1'b0;
    return v;
  endfunction

  initial begin
    RST_N = 1'b0; PC_SEL = '0; PC_WE = 1'b0;
    JAL = '0; JALR = '0; BRANCH = '0; MTVEC = '0; MEPC = '0;
    IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; IMEM_RDATA = '0;
    model_pc = 32'h0; trap_pending = 1'b0; bad_exp = '0;

    // Reset values
    step(); step();
    check("rst_pc", PC, 32'h0);
    check("rst_instr", INSTR, 32'h0);
    check("rst_ivalid", {31'd0, INSTR_VALID}, 32'd0);
    check("rst_trap", {31'd0, TRAP_MISALIGN}, 32'd0);
    check("rst_bad", BAD_ADDR, 32'h0);
    check("rst_req", {31'd0, IMEM_REQ}, 32'd1);
    RST_N = 1'b1;

    // Sequential fetch with zero wait states: 0x0, 0x4, 0x8
    fetch(0, 0, 1'b0);
    advance(3'd0, '0, '0, '0, '0, '0);
    fetch(0, 0, 1'b0);
    advance(3'd0, '0, '0, '0, '0, '0);
    fetch(0, 0, 1'b0);
    check("seq_addr_8", PC, 32'h8);

    // Stalled memory, with stray PC_WE during REQ/WAIT that must be ignored
    advance(3'd0, '0, '0, '0, '0, '0);
    fetch(2, 3, 1'b1);

    // Jumps and return
    advance(3'd3, 32'h100, '0, '0, '0, '0);
    fetch(0, 0, 1'b0);
    advance(3'd1, '0, 32'h201, '0, '0, '0);
    check("jalr_no_trap", {31'd0, TRAP_MISALIGN}, 32'd0);
    fetch(0, 0, 1'b0);
    advance(3'd5, '0, '0, '0, '0, 32'h44);
    fetch(0, 0, 1'b0);

    // Misaligned branch redirects to MTVEC
    advance(3'd2, '0, '0, 32'h0000_0106, 32'h80, '0);
    check("mis_pc", PC, 32'h80);
    check("mis_bad", BAD_ADDR, 32'h106);
    fetch(1, 0, 1'b0);

    // Wrap from the top of the address space
    advance(3'd3, 32'hFFFF_FFFC, '0, '0, '0, '0);
    fetch(0, 1, 1'b0);
    advance(3'd0, '0, '0, '0, '0, '0);
    check("wrap_pc", PC, 32'h0);
    fetch(0, 0, 1'b0);

    // Randomized targets, selects, stalls and holds
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        step();
        check("hold_ivalid", {31'd0, INSTR_VALID}, 32'd1);
        check("hold_pc", PC, model_pc);
      end
      advance(3'($urandom_range(0, 7)), rand_tgt(1'b0), rand_tgt(1'b1), rand_tgt(1'b0),
              $urandom, $urandom);
      fetch($urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 1) == 1));
    end

    // Reset during S_WAIT with a stale response after release
    advance(3'd3, 32'h0000_0300, '0, '0, '0, '0);
    check("pre_rst_addr", IMEM_ADDR, 32'h300);
    IMEM_GNT = 1'b1;
    step();
    IMEM_GNT = 1'b0;
    check("pre_rst_wait", {31'd0, IMEM_REQ}, 32'd0);
    RST_N = 1'b0;
    #1;
    check("midrst_pc", PC, 32'h0);
    check("midrst_instr", INSTR, 32'h0);
    check("midrst_ivalid", {31'd0, INSTR_VALID}, 32'd0);
    check("midrst_req", {31'd0, IMEM_REQ}, 32'd1);
    check("midrst_bad", BAD_ADDR, 32'h0);
    step();
    RST_N       = 1'b1;
    IMEM_RVALID = 1'b1;
    IMEM_RDATA  = 32'hDEAD_BEEF;
    step();
    IMEM_RVALID = 1'b0;
    check("stale_ivalid", {31'd0, INSTR_VALID}, 32'd0);
    check("stale_instr", INSTR, 32'h0);
    model_pc     = 32'h0;
    trap_pending = 1'b0;
    fetch(0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
